acumulador_csa_seq: RTL
=======================

// Module: acumulador_csa_seq
// PURPOSE
//  Sequential multi-operand accumulator on carry-save arithmetic. Each beat brings three
//  N-bit unsigned operands; they are compressed with the running redundant (sum, carry)
//  state by 3:2 CSA stages, with no carry propagation per beat. On the last beat, one
//  final carry-propagate add resolves the packet total. Sits between operand producers
//  and any consumer needing a packet sum (dot products, checksums), with valid/ready on both sides.
// PARAMETERS
//  N   8  operand width (A, B, C)
//  G   2  guard bits; accumulator width W = N+G
//  CW  8  beat-counter width
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  in_valid   in   1   operand beat valid
//  in_ready   out  1   block accepts a beat
//  in_last    in   1   marks final beat of packet (qualified by in_valid&in_ready)
//  A, B, C    in   N   unsigned operands, zero-extended to W
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  soma       out  W   packet total mod 2^W
//  Carry      out  1   overflow: true total >= 2^W
//  n_beats    out  CW  beats in packet, saturating at 2^CW-1
// BEHAVIOUR
//  - Reset (async, any state): state=ACC, S=Cy=0, ovf=0, cnt=0, out_valid=0, soma=0,
//    Carry=0, n_beats=0. in_ready=0 while rst is high; it is 1 from the first edge after release.
//  - States: ACC -> RES on an accepted beat with in_last. RES -> OUT after the final add
//    completes. OUT -> ACC on out_valid&out_ready.
//  - in_ready = (state==ACC) & !rst. No beat is accepted in RES or OUT; there is no overlap of packets.
//  - Accepted beat: the 5 operands {S, Cy, A, B, C} are reduced to 2 by three 3:2 CSA
//    stages (sum = x^y^z, carry = majority<<1) and registered as S, Cy.
//  - Every carry bit shifted out past bit W-1 in any stage sets the sticky ovf.
//  - Each accepted beat increments cnt (saturating).
//  - RES: {cout, soma} = S + Cy (W-bit add). Carry = ovf | cout. n_beats = cnt.
//  - OUT: out_valid=1. soma, Carry and n_beats stay stable until the handshake.
//    On handshake, S, Cy, ovf and cnt clear; soma, Carry and n_beats keep their values.
//    out_valid drops the next cycle.
//  - Latency: last beat accepted at edge t -> out_valid high after edge t+1 (t+2 with CPA_PIPE_EN).
//    With out_ready held high, in_ready is 1 again one cycle after out_valid.
//  - Single-beat packet (in_last on the first beat) is legal: total = A+B+C.
//  - in_valid low in ACC: state holds. Beats without in_last keep accumulating with no limit;
//    overflow is reported through Carry only.
//  - in_last with in_valid low is ignored. in_valid in RES or OUT is not accepted and is not lost:
//    the source holds it.
//  - Reset mid-packet or mid-OUT drops the partial or pending result entirely.
// CONFIGURATION
//  CPA_PIPE_EN defined:
//    - RES takes 2 cycles. Cycle 1 adds the low ceil(W/2) bits and registers the carry.
//    - Cycle 2 adds the high bits with that carry.
//    - Results are identical; latency is +1.
//  CPA_PIPE_EN undefined: single-cycle W-bit add in RES.
// TESTING (N=8, G=2, CW=8, W=10)
//  1. Single beat A=3,B=5,C=7,last -> soma=15, Carry=0, n_beats=1, out_valid one edge after accept.
//  2. Beats (100,200,50),(10,20,30,last) -> soma=410, Carry=0, n_beats=2.
//  3. Four beats, each 255,255,255, last on 4th -> total 3060: soma=1012, Carry=1, n_beats=4.
//  4. After test 2, hold out_ready=0 for 5 cycles -> soma=410 stable, out_valid=1, in_ready=0,
//     in_valid beats ignored. Then out_ready=1 -> one handshake, in_ready=1 next cycle.
//  5. Two beats (9,9,9) with no last, then rst pulse mid-cycle -> out_valid=0, in_ready=0 during rst.
//     Next packet (1,1,1,last) -> soma=3, n_beats=1.
//  6. CPA_PIPE_EN defined: rerun tests 1-3 -> same values, out_valid one cycle later.

Source files
------------

// File: rtl/acumulador_csa_seq.sv
// rtl/acumulador_csa_seq.sv - carry-save multi-operand packet accumulator with valid/ready handshakes
// Optional CPA_PIPE_EN: splits the final carry-propagate add over two cycles.
module acumulador_csa_seq #(
    parameter int N  = 8,
    parameter int G  = 2,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    input  logic [N-1:0]      C,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N+G-1:0]    soma,
    output logic              Carry,
    output logic [CW-1:0]     n_beats
);
    localparam int W = N + G;

    typedef enum logic [1:0] {ST_ACC, ST_RES, ST_RES2, ST_OUT} state_t;

    state_t         state_q;
    logic [W-1:0]   s_q, cy_q;
    logic           ovf_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   soma_q;
    logic           carry_q;
    logic [CW-1:0]  n_beats_q;
    logic           out_valid_q;

    logic [W-1:0]   a_x, b_x, c_x;
    logic [W-1:0]   s1, s2, s_d;
    logic [W:0]     c1, c2, c3;
    logic [W-1:0]   cy_d;
    logic           ovf_d;

    // Three 3:2 stages reduce {S, Cy, A, B, C} to a new redundant pair; bit W of each
    // shifted carry is weight 2^W and is only remembered in the sticky overflow.
    always_comb begin
        a_x   = {{G{1'b0}}, A};
        b_x   = {{G{1'b0}}, B};
        c_x   = {{G{1'b0}}, C};
        s1    = s_q ^ cy_q ^ a_x;
        c1    = {(s_q & cy_q) | (s_q & a_x) | (cy_q & a_x), 1'b0};
        s2    = s1 ^ c1[W-1:0] ^ b_x;
        c2    = {(s1 & c1[W-1:0]) | (s1 & b_x) | (c1[W-1:0] & b_x), 1'b0};
        s_d   = s2 ^ c2[W-1:0] ^ c_x;
        c3    = {(s2 & c2[W-1:0]) | (s2 & c_x) | (c2[W-1:0] & c_x), 1'b0};
        cy_d  = c3[W-1:0];
        ovf_d = ovf_q | c1[W] | c2[W] | c3[W];
    end

`ifdef CPA_PIPE_EN
    localparam int L = (W + 1) / 2;
    localparam int H = W - L;
    logic [L-1:0]   lo_q;
    logic           lo_c_q;
    logic [L:0]     cpa_lo;
    logic [H:0]     cpa_hi;
    assign cpa_lo = {1'b0, s_q[L-1:0]} + {1'b0, cy_q[L-1:0]};
    assign cpa_hi = {1'b0, s_q[W-1:L]} + {1'b0, cy_q[W-1:L]} + {{H{1'b0}}, lo_c_q};
`else
    logic [W:0]     cpa_full;
    assign cpa_full = {1'b0, s_q} + {1'b0, cy_q};
`endif

    assign in_ready  = (state_q == ST_ACC) & ~rst;
    assign out_valid = out_valid_q;
    assign soma      = soma_q;
    assign Carry     = carry_q;
    assign n_beats   = n_beats_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            s_q         <= '0;
            cy_q        <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            soma_q      <= '0;
            carry_q     <= 1'b0;
            n_beats_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef CPA_PIPE_EN
            lo_q        <= '0;
            lo_c_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        s_q   <= s_d;
                        cy_q  <= cy_d;
                        ovf_q <= ovf_d;
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + CW'(1);
                        if (in_last)
                            state_q <= ST_RES;
                    end
                end
`ifdef CPA_PIPE_EN
                ST_RES: begin
                    lo_q    <= cpa_lo[L-1:0];
                    lo_c_q  <= cpa_lo[L];
                    state_q <= ST_RES2;
                end
                ST_RES2: begin
                    soma_q      <= {cpa_hi[H-1:0], lo_q};
                    carry_q     <= ovf_q | cpa_hi[H];
                    n_beats_q   <= cnt_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
`else
                ST_RES: begin
                    soma_q      <= cpa_full[W-1:0];
                    carry_q     <= ovf_q | cpa_full[W];
                    n_beats_q   <= cnt_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
`endif
                ST_OUT: begin
                    // Published result stays in soma/Carry/n_beats; only the accumulator clears.
                    if (out_ready) begin
                        s_q         <= '0;
                        cy_q        <= '0;
                        ovf_q       <= 1'b0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end
endmodule
